// File: rtl/instr_sched_ctrl.sv
// Two-writer, one-reader scheduler that runs an external instruction register as a circular FIFO.
// Writes go out one cycle after acceptance; an entry becomes readable one edge after its write.
package instr_sched_pkg;
   localparam int ADDR_W = 5;

   typedef logic [3:0]        opcode_t;
   typedef logic [7:0]        operand_t;
   typedef logic [ADDR_W-1:0] address_t;

   typedef struct packed {
      opcode_t  opcode;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;

   localparam opcode_t OP_ADD = 4'h1;
endpackage

module instr_sched_ctrl
   import instr_sched_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,

   input  logic         req0_valid,
   output logic         req0_ready,
   input  opcode_t      req0_opcode,
   input  operand_t     req0_op_a,
   input  operand_t     req0_op_b,

   input  logic         req1_valid,
   output logic         req1_ready,
   input  opcode_t      req1_opcode,
   input  operand_t     req1_op_a,
   input  operand_t     req1_op_b,

   output logic         load_en,
   output address_t     write_pointer,
   output address_t     read_pointer,
   output opcode_t      opcode,
   output operand_t     operand_a,
   output operand_t     operand_b,
   input  instruction_t instruction_word,

   output logic         rd_valid,
   input  logic         rd_ready,
   output instruction_t rd_instr,

   output logic [5:0]   count
);

   localparam logic [5:0] DEPTH_C = 6'(DEPTH);
   localparam address_t   LAST_IDX = address_t'(DEPTH - 1);

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // ready never depends on data, only on occupancy, flush, reset and the peer's valid.

   address_t   wptr;
   address_t   rptr;
   address_t   wptr_nxt;
   address_t   rptr_nxt;
   logic [5:0] count_q;
   logic [5:0] avail;
   logic       load_q;
   logic       prio;
   logic       full;
   logic       can_accept;
   logic       accept;
   logic       pop;

   assign full       = (count_q == DEPTH_C);
   assign can_accept = reset_n && !full && !flush;

   assign req0_ready = can_accept && req0_valid && (!req1_valid || !prio);
   assign req1_ready = can_accept && req1_valid && (!req0_valid ||  prio);
   assign accept     = req0_ready || req1_ready;

   assign rd_valid = (avail != 6'd0);
   assign pop      = rd_valid && rd_ready;
   assign rd_instr = instruction_word;

   assign wptr_nxt = (wptr == LAST_IDX) ? '0 : wptr + address_t'(1);
   assign rptr_nxt = (rptr == LAST_IDX) ? '0 : rptr + address_t'(1);

   // A write still pending when flush arrives must not land in the register.
   assign load_en      = load_q && !flush;
   assign read_pointer = rptr;
   assign count        = count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr          <= '0;
         rptr          <= '0;
         count_q       <= '0;
         avail         <= '0;
         load_q        <= 1'b0;
         prio          <= 1'b0;
         write_pointer <= '0;
      end else if (flush) begin
         wptr          <= '0;
         rptr          <= '0;
         count_q       <= '0;
         avail         <= '0;
         load_q        <= 1'b0;
         prio          <= 1'b0;
         write_pointer <= '0;
      end else begin
         load_q <= accept;
         if (accept) begin
            write_pointer <= wptr;
            wptr          <= wptr_nxt;
            // Priority moves to whichever requester was not granted.
            prio          <= req0_ready;
         end
         if (pop) begin
            rptr <= rptr_nxt;
         end
         case ({accept, pop})
            2'b10:   count_q <= count_q + 6'd1;
            2'b01:   count_q <= count_q - 6'd1;
            default: count_q <= count_q;
         endcase
         // Readability trails the write strobe by one edge.
         case ({load_q, pop})
            2'b10:   avail <= avail + 6'd1;
            2'b01:   avail <= avail - 6'd1;
            default: avail <= avail;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         opcode    <= '0;
         operand_a <= '0;
         operand_b <= '0;
      end else if (accept && !flush) begin
         if (req0_ready) begin
            opcode    <= req0_opcode;
            operand_a <= req0_op_a;
            operand_b <= req0_op_b;
         end else begin
            opcode    <= req1_opcode;
            operand_a <= req1_op_a;
            operand_b <= req1_op_b;
         end
      end
   end

endmodule

// File: tb/tb_instr_sched_ctrl.sv
// Randomized and directed bench for instr_sched_ctrl against a queue-based FIFO model.
// Inputs change on the falling edge; all outputs are checked shortly after.
module tb_instr_sched_ctrl;
   import instr_sched_pkg::*;

   localparam int DEPTH = 32;
   localparam int IW    = $bits(instruction_t);

   logic         clk;
   logic         reset_n;
   logic         flush;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   opcode_t      req0_opcode, req1_opcode;
   operand_t     req0_op_a, req0_op_b, req1_op_a, req1_op_b;
   logic         load_en;
   address_t     write_pointer, read_pointer;
   opcode_t      opcode;
   operand_t     operand_a, operand_b;
   instruction_t instruction_word;
   logic         rd_valid;
   logic         rd_ready;
   instruction_t rd_instr;
   logic [5:0]   count;

   instruction_t mem [DEPTH];

   int total = 0;
   int bad   = 0;

   // Model state: contents in order, accept/pop totals since clear, and the last write.
   logic [IW-1:0] exp_q[$];
   int            m_wcnt;
   int            m_rcnt;
   int            m_wp;
   logic          m_prio;
   logic          m_last_acc;
   logic [IW-1:0] m_last_item;

   instr_sched_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_op_a(req0_op_a), .req0_op_b(req0_op_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_op_a(req1_op_a), .req1_op_b(req1_op_b),
      .load_en(load_en), .write_pointer(write_pointer), .read_pointer(read_pointer),
      .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
      .instruction_word(instruction_word),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_instr(rd_instr),
      .count(count)
   );

   // Clock/reset block and the instruction register the DUT drives.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b};
   end
   assign instruction_word = mem[read_pointer];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_wcnt     = 0;
      m_rcnt     = 0;
      m_wp       = 0;
      m_prio     = 1'b0;
      m_last_acc = 1'b0;
   endtask

   task automatic expected_grants(output logic g0, output logic g1);
      logic ok;
      ok = !flush && (exp_q.size() < DEPTH);
      g0 = ok && req0_valid && (!req1_valid || m_prio == 1'b0);
      g1 = ok && req1_valid && (!req0_valid || m_prio == 1'b1);
   endtask

   task automatic check_outputs();
      logic g0, g1;
      int   sz, avail;
      expected_grants(g0, g1);
      sz    = exp_q.size();
      avail = sz - int'(m_last_acc);
      chk("req0_ready", 32'(req0_ready), 32'(g0));
      chk("req1_ready", 32'(req1_ready), 32'(g1));
      chk("load_en", 32'(load_en), 32'(m_last_acc && !flush));
      chk("write_pointer", 32'(write_pointer), 32'(m_wp));
      if (m_last_acc) chk("write_data", 32'({opcode, operand_a, operand_b}), 32'(m_last_item));
      chk("read_pointer", 32'(read_pointer), 32'(m_rcnt % DEPTH));
      chk("count", 32'(count), 32'(sz));
      chk("rd_valid", 32'(rd_valid), 32'(avail != 0));
      if (avail != 0) chk("rd_instr", 32'(rd_instr), 32'(exp_q[0]));
   endtask

   task automatic model_edge();
      logic g0, g1;
      expected_grants(g0, g1);
      if (flush) begin
         model_clear();
      end else begin
         if ((exp_q.size() - int'(m_last_acc)) != 0 && rd_ready) begin
            void'(exp_q.pop_front());
            m_rcnt++;
         end
         if (g0 || g1) begin
            m_last_item = g0 ? {req0_opcode, req0_op_a, req0_op_b}
                             : {req1_opcode, req1_op_a, req1_op_b};
            exp_q.push_back(m_last_item);
            m_wp   = m_wcnt % DEPTH;
            m_wcnt++;
            m_prio = g0;
            m_last_acc = 1'b1;
         end else begin
            m_last_acc = 1'b0;
         end
      end
   endtask

   // Driver tasks: inputs are set at the falling edge, then one full cycle runs.
   task automatic cycle();
      #1;
      check_outputs();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic rand_data();
      req0_opcode = opcode_t'($urandom_range(0, 15));
      req0_op_a   = operand_t'($urandom_range(0, 255));
      req0_op_b   = operand_t'($urandom_range(0, 255));
      req1_opcode = opcode_t'($urandom_range(0, 15));
      req1_op_a   = operand_t'($urandom_range(0, 255));
      req1_op_b   = operand_t'($urandom_range(0, 255));
   endtask

   task automatic drive(input logic v0, input logic v1, input logic rr, input logic fl);
      req0_valid = v0;
      req1_valid = v1;
      rd_ready   = rr;
      flush      = fl;
   endtask

   task automatic do_flush();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      flush = 1'b0;
   endtask

   task automatic check_reset_values();
      chk("rst_load_en", 32'(load_en), 32'd0);
      chk("rst_write_pointer", 32'(write_pointer), 32'd0);
      chk("rst_read_pointer", 32'(read_pointer), 32'd0);
      chk("rst_opcode", 32'(opcode), 32'd0);
      chk("rst_operand_a", 32'(operand_a), 32'd0);
      chk("rst_operand_b", 32'(operand_b), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_req0_ready", 32'(req0_ready), 32'd0);
      chk("rst_req1_ready", 32'(req1_ready), 32'd0);
   endtask

   initial begin
      reset_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      rand_data();
      model_clear();
      #1 reset_n = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_reset_values();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;

      // Single write of ADD 5,3 through to the read port.
      req0_opcode = OP_ADD;
      req0_op_a   = 8'd5;
      req0_op_b   = 8'd3;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      cycle();
      chk("single_rd_instr", 32'(rd_instr), 32'({OP_ADD, 8'd5, 8'd3}));
      chk("single_count", 32'(count), 32'd1);
      do_flush();

      // Contention: both requesters for four cycles.
      for (int i = 0; i < 4; i++) begin
         rand_data();
         drive(1'b1, 1'b1, 1'b0, 1'b0);
         cycle();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      chk("contention_count", 32'(count), 32'd4);
      do_flush();

      // Fill to full, then pop with a request pending.
      for (int i = 0; i < DEPTH; i++) begin
         rand_data();
         drive(1'b1, ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
         cycle();
      end
      rand_data();
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      cycle();
      chk("full_pop_count", 32'(count), 32'd31);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) cycle();
      do_flush();

      // Random traffic long enough to wrap both pointers several times.
      for (int i = 0; i < 400; i++) begin
         rand_data();
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) != 0), 1'b0);
         cycle();
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (DEPTH + 2) cycle();
      chk("drain_count", 32'(count), 32'd0);

      // Flush while a write is pending and a request is still valid.
      for (int i = 0; i < 5; i++) begin
         rand_data();
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         cycle();
      end
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      chk("flush_write_pointer", 32'(write_pointer), 32'd0);

      // Reset asserted between edges during back-to-back writes.
      for (int i = 0; i < 3; i++) begin
         rand_data();
         drive(1'b1, 1'b1, 1'b0, 1'b0);
         cycle();
      end
      #1 reset_n = 1'b0;
      #1;
      check_reset_values();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_clear();
      rand_data();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_sched_ctrl.md
INSTR_SCHED_CTRL -- requirements
Module: instr_sched_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH, default 32: number of instruction register entries; equals 2**$bits(address_t).

Ports:
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port flush, input, 1, synchronous clear of all queue state.
REQ-005 The block SHALL have ports req0_valid / req1_valid, input, 1, requester write requests.
REQ-006 The block SHALL have ports req0_ready / req1_ready, output, 1, request accepted this edge when valid and ready are both 1.
REQ-007 The block SHALL have ports req0_opcode / req1_opcode, input, opcode_t, requested opcode.
REQ-008 The block SHALL have ports req0_op_a / req1_op_a and req0_op_b / req1_op_b, input, operand_t, requested operands.
REQ-009 The block SHALL have port load_en, output, 1, write strobe to the instruction register.
REQ-010 The block SHALL have ports write_pointer and read_pointer, output, address_t, instruction register addresses.
REQ-011 The block SHALL have ports opcode, output, opcode_t, and operand_a / operand_b, output, operand_t, instruction register write data.
REQ-012 The block SHALL have port instruction_word, input, instruction_t, instruction register read data (combinational at read_pointer).
REQ-013 The block SHALL have ports rd_valid, output, 1; rd_ready, input, 1; rd_instr, output, instruction_t: in-order consumer port.
REQ-014 The block SHALL have port count, output, 6, number of occupied entries (0..DEPTH).

Function
REQ-015 The block SHALL operate the instruction register as a circular FIFO shared by two writers; wptr and rptr wrap from DEPTH-1 to 0.
REQ-016 The full signal SHALL be (count == DEPTH); no request is accepted when full, even if a read pops on the same edge.
REQ-017 Arbitration SHALL be round-robin: a lone valid requester is granted; when both are valid, the requester indicated by a 1-bit priority register (reset 0 = req0) is granted.
REQ-018 reqN_ready SHALL be combinational: !full && !flush && reqN_valid && (other not valid || priority == N); at most one ready is high per cycle.
REQ-019 After any accept, priority SHALL point to the non-accepted requester; otherwise it holds.
REQ-020 On accept at edge N: opcode/operand_a/operand_b SHALL register the granted fields; write_pointer <= wptr; load_en <= 1; wptr increments; count increments.
REQ-021 load_en SHALL be 0 in every cycle following an edge with no accept; back-to-back accepts keep load_en high with a new write_pointer each cycle.
REQ-022 An entry SHALL become readable (avail increments) at edge N+1, when the instruction register captures it; avail SHALL never exceed count.
REQ-023 rd_valid SHALL be (avail != 0); rd_instr SHALL equal instruction_word; read_pointer SHALL equal rptr (registered).
REQ-024 On rd_valid && rd_ready: rptr increments; avail and count decrement; simultaneous accept and pop SHALL leave count unchanged.
REQ-025 rd_ready while rd_valid = 0 SHALL have no effect.
REQ-026 flush SHALL, at the next edge, zero wptr, rptr, count, avail and load_en, and force the priority register to 0; requests are not accepted in the flush cycle and a pending load_en write is suppressed.

Reset
REQ-027 While reset_n = 0: load_en = 0, write_pointer = 0, read_pointer = 0, opcode = 0, operand_a = 0, operand_b = 0, count = 0, rd_valid = 0, both readies = 0, priority = req0; reset asserted mid-write cancels the write (load_en drops immediately).

Verification
REQ-028 Single write: req0_valid with opcode ADD, op_a 5, op_b 3 -> req0_ready = 1; next cycle load_en = 1, write_pointer = 0, operand_a = 5; two cycles later rd_valid = 1, rd_instr = {ADD, 5, 3}, count = 1.
REQ-029 Contention: both valid for 4 cycles -> grants req0, req1, req0, req1; write_pointers 0..3; count = 4.
REQ-030 Full: 32 accepts without reads -> count = 32, both readies 0; a pop with a simultaneous valid request -> count = 31, no accept that cycle.
REQ-031 Wrap: 40 writes interleaved with reads -> write_pointer and read_pointer go 31 -> 0; data read back in write order.
REQ-032 Flush with 5 entries and load_en high -> next cycle count = 0, rd_valid = 0, load_en = 0, pointers 0.
REQ-033 reset_n low during back-to-back writes -> all outputs reach reset values without waiting for a clock edge; the first accept after release uses write_pointer 0.
